// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg -- shared definitions for the VGA timing generator.
//
// Holds the per-axis phase enum used by the phase machines, the counter
// width, the default 640x480@60 timing constants, and a helper that derives
// an axis total from its four segment lengths.
//
// The optional output register stage is selected elsewhere with the
// VGA_OUT_REG_EN macro; nothing in this package depends on it.
package vga_timing_pkg;

    // Width of pix_x / pix_y and of both axis counters.
    localparam int CNT_W = 10;

    // Default 640x480@60 timing (25.175 MHz pixel rate).
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // Phase of one axis within its line (horizontal) or frame (vertical).
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_e;

    // Number of counts in one full period of an axis.
    function automatic int axis_total(input int visible, input int fp,
                                      input int sync_len, input int bp);
        return visible + fp + sync_len + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one axis (horizontal or vertical) of the VGA timing.
//
// A modulo-TOTAL counter plus the four-state phase machine
// ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE that tracks which segment the
// count is in. The phase is held in a register alongside the count so the
// sync/visible decode downstream is a plain compare on flops.
//
// Ports:
//   clk      in   system clock, posedge
//   rst      in   asynchronous active-high reset (count 0, phase ACTIVE)
//   en       in   advance the count by one on this edge
//   cnt_q    out  current count, 0..TOTAL-1
//   phase_q  out  current phase (also serves as the state debug view)
//   wrap     out  high when en is set and the count is at TOTAL-1, i.e. this
//                 edge returns the count to 0; used to step the next axis
//
// Handshake: there is none; en is a plain per-edge strobe, no backpressure.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE  = DEF_H_VISIBLE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC_LEN = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_q,
    output phase_e           phase_q,
    output logic             wrap
);

    // Counts at which each later phase begins, and the last count of the axis.
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(VISIBLE + FP);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(VISIBLE + FP + SYNC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT    =
        CNT_W'(axis_total(VISIBLE, FP, SYNC_LEN, BP) - 1);

    logic [CNT_W-1:0] cnt_d;
    phase_e           phase_d;

    always_comb begin
        wrap    = en && (cnt_q == LAST_CNT);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            // The phase moves on the same edge the count reaches the start
            // of the next segment, so phase_q always matches cnt_q.
            case (phase_q)
                ACTIVE:  if (cnt_d == FRONT_START) phase_d = FRONT;
                FRONT:   if (cnt_d == SYNC_START)  phase_d = SYNC;
                SYNC:    if (cnt_d == BACK_START)  phase_d = BACK;
                BACK:    if (wrap)                 phase_d = ACTIVE;
                default:                           phase_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing -- VGA sync / position generator.
//
// Two vga_axis_counter instances: the horizontal one steps on every clk with
// pix_en=1, the vertical one steps on the edge where the horizontal count
// wraps. Sync and visible flags are decoded from the registered phases, so
// no output has a combinational path from pix_en.
//
// Ports:
//   clk         in   system clock, posedge
//   rst         in   asynchronous active-high reset
//   pix_en      in   pixel-rate strobe; one pixel step per clk with pix_en=1
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  current pixel is in the visible area
//   pix_x       out  horizontal count, 0..H_TOTAL-1
//   pix_y       out  vertical count, 0..V_TOTAL-1
//   frame_tick  out  one-clk pulse at the start of vertical blanking
//
// Build option: define VGA_OUT_REG_EN to add one register stage on every
// output (all outputs delayed uniformly by one clk, same reset values).
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] H_LAST_VIS = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_VISIBLE - 1);

    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] v_cnt_q;
    phase_e           h_phase_q;
    phase_e           v_phase_q;
    logic             h_wrap;
    logic             v_wrap;

    // started_q keeps video_on low between reset release and the first
    // pix_en, even though both phases already read ACTIVE.
    logic started_q, started_d;
    logic frame_tick_q, frame_tick_d;

    vga_axis_counter #(
        .VISIBLE  (H_VISIBLE),
        .FP       (H_FP),
        .SYNC_LEN (H_SYNC),
        .BP       (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .en      (pix_en),
        .cnt_q   (h_cnt_q),
        .phase_q (h_phase_q),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE  (V_VISIBLE),
        .FP       (V_FP),
        .SYNC_LEN (V_SYNC),
        .BP       (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .en      (h_wrap),
        .cnt_q   (v_cnt_q),
        .phase_q (v_phase_q),
        .wrap    (v_wrap)
    );

    always_comb begin
        started_d    = started_q | pix_en;
        // Pulse on the edge leaving the last visible pixel of the last
        // visible line; it drops on the next clk whether or not pix_en is set.
        frame_tick_d = pix_en && (h_cnt_q == H_LAST_VIS) && (v_cnt_q == V_LAST_VIS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            started_q    <= started_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Decode from state registers only.
    logic             hsync_s;
    logic             vsync_s;
    logic             video_on_s;

    always_comb begin
        hsync_s    = (h_phase_q != SYNC);
        vsync_s    = (v_phase_q != SYNC);
        video_on_s = started_q && (h_phase_q == ACTIVE) && (v_phase_q == ACTIVE);
    end

`ifdef VGA_OUT_REG_EN
    logic             hsync_q, vsync_q, video_on_q, frame_tick_oq;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_tick_oq <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            hsync_q       <= hsync_s;
            vsync_q       <= vsync_s;
            video_on_q    <= video_on_s;
            frame_tick_oq <= frame_tick_q;
            pix_x_q       <= h_cnt_q;
            pix_y_q       <= v_cnt_q;
        end
    end

    always_comb begin
        hsync      = hsync_q;
        vsync      = vsync_q;
        video_on   = video_on_q;
        frame_tick = frame_tick_oq;
        pix_x      = pix_x_q;
        pix_y      = pix_y_q;
    end
`else
    always_comb begin
        hsync      = hsync_s;
        vsync      = vsync_s;
        video_on   = video_on_s;
        frame_tick = frame_tick_q;
        pix_x      = h_cnt_q;
        pix_y      = v_cnt_q;
    end
`endif

    // The vertical wrap has no consumer; a frame restart is visible as
    // (pix_x,pix_y) returning to (0,0).
    logic unused_v_wrap;
    always_comb unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing -- directed, table-driven bench for vga_timing.
//
// The DUT runs with a shrunken timing (line of 20 pixels, frame of 12 lines)
// so whole frames fit in a short run; every expected value below is worked
// out by hand for these numbers:
//   H: visible 0..9, front 10..11, sync 12..14, back 15..19
//   V: visible 0..5, front 6,      sync 7..8,   back 9..11
// Last visible pixel is (9,5); frame_tick follows the edge (9,5)->(10,5).
module tb_vga_timing;

    localparam int HV = 10, HF = 2, HS = 3, HB = 5;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 3;
    localparam int H_TOT = HV + HF + HS + HB;   // 20
    localparam int V_TOT = VV + VF + VS + VB;   // 12

`ifdef VGA_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       hsync, vsync, video_on, frame_tick;
    logic [9:0] pix_x, pix_y;

    always #5 clk = ~clk;

    vga_timing #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_tick (frame_tick)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int ft_cnt = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Wait for the falling edge, note any frame_tick, then set pix_en for
    // the following rising edge.
    task automatic tick_en(input logic en);
        @(negedge clk);
        if (frame_tick === 1'b1) ft_cnt++;
        pix_en = en;
    endtask

    // n pixel steps, each followed by gap idle clks, then two idle clks so
    // any output register stage has caught up before comparing.
    task automatic run(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick_en(1'b1);
            for (int g = 0; g < gap; g++) tick_en(1'b0);
        end
        tick_en(1'b0);
        tick_en(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        ft_cnt = 0;
    endtask

    task automatic check_outs(input string tag, input int x, input int y,
                              input logic hs, input logic vs, input logic von);
        check({tag, " pix_x"},    int'(pix_x),    x);
        check({tag, " pix_y"},    int'(pix_y),    y);
        check({tag, " hsync"},    int'(hsync),    int'(hs));
        check({tag, " vsync"},    int'(vsync),    int'(vs));
        check({tag, " video_on"}, int'(video_on), int'(von));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   n;
        int   gap;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int hi, at, lows, first;
        logic [9:0] mh, mv;
        logic [19:0] exp_v;

        // Cumulative from one reset: n steps taken before each compare.
        vecs[0]  = '{n: 0,   gap: 0, x: 0,  y: 0,  hs: 1, vs: 1, von: 0}; // no pix_en yet
        vecs[1]  = '{n: 1,   gap: 0, x: 1,  y: 0,  hs: 1, vs: 1, von: 1};
        vecs[2]  = '{n: 8,   gap: 1, x: 9,  y: 0,  hs: 1, vs: 1, von: 1}; // last visible
        vecs[3]  = '{n: 1,   gap: 0, x: 10, y: 0,  hs: 1, vs: 1, von: 0}; // front porch
        vecs[4]  = '{n: 2,   gap: 0, x: 12, y: 0,  hs: 0, vs: 1, von: 0}; // sync start
        vecs[5]  = '{n: 2,   gap: 2, x: 14, y: 0,  hs: 0, vs: 1, von: 0}; // sync end
        vecs[6]  = '{n: 1,   gap: 0, x: 15, y: 0,  hs: 1, vs: 1, von: 0}; // back porch
        vecs[7]  = '{n: 4,   gap: 0, x: 19, y: 0,  hs: 1, vs: 1, von: 0};
        vecs[8]  = '{n: 1,   gap: 0, x: 0,  y: 1,  hs: 1, vs: 1, von: 1}; // line wrap
        vecs[9]  = '{n: 100, gap: 3, x: 0,  y: 6,  hs: 1, vs: 1, von: 0}; // 1-in-4 strobe
        vecs[10] = '{n: 20,  gap: 0, x: 0,  y: 7,  hs: 1, vs: 0, von: 0}; // vsync start
        vecs[11] = '{n: 13,  gap: 0, x: 13, y: 7,  hs: 0, vs: 0, von: 0};
        vecs[12] = '{n: 27,  gap: 0, x: 0,  y: 9,  hs: 1, vs: 1, von: 0}; // vsync end
        vecs[13] = '{n: 59,  gap: 0, x: 19, y: 11, hs: 1, vs: 1, von: 0}; // last count
        vecs[14] = '{n: 1,   gap: 0, x: 0,  y: 0,  hs: 1, vs: 1, von: 1}; // frame wrap

        // Reset values, checked while rst is still asserted.
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 1'b1, 1'b1, 1'b0);
        check("reset frame_tick", int'(frame_tick), 0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            run(vecs[i].n, vecs[i].gap);
            check_outs($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                       vecs[i].hs, vecs[i].vs, vecs[i].von);
        end
        check("table frame_tick count", ft_cnt, 1);

        // One full line: hsync low for exactly HS clks starting at h=12.
        do_reset();
        lows  = 0;
        first = -1;
        for (int i = 0; i < H_TOT + 3; i++) begin
            @(negedge clk);
            if (!hsync) begin
                lows++;
                if (first < 0) first = i;
            end
            pix_en = (i < H_TOT);
        end
        check("line hsync low clks", lows, HS);
        check("line hsync first", first, HV + HF + LAT);
        check("line pix_x", int'(pix_x), 0);
        check("line pix_y", int'(pix_y), 1);

        // frame_tick: exactly one clk after (9,5)->(10,5), then pix_en held 0.
        do_reset();
        run(VV * H_TOT - H_TOT + HV - 1, 0);      // to (9,5)
        check("pre-tick video_on", int'(video_on), 1);
        check("pre-tick frame_tick count", ft_cnt, 0);
        tick_en(1'b1);
        hi = 0;
        at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                hi++;
                at = i;
            end
            pix_en = 1'b0;
        end
        check("tick high clks", hi, 1);
        check("tick position", at, LAT);
        check_outs("tick hold", HV, VV - 1, 1'b1, 1'b1, 1'b0);

        // Reset mid-frame at (5,3): immediate reset values, no stray tick.
        do_reset();
        run(3 * H_TOT + 5, 0);
        check_outs("pre-rst", 5, 3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("async rst", 0, 0, 1'b1, 1'b1, 1'b0);
        check("async rst frame_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst    = 1'b0;
        ft_cnt = 0;
        repeat (3) tick_en(1'b0);
        check("idle after rst video_on", int'(video_on), 0);
        run(VV * H_TOT - H_TOT + HV - 1, 0);      // back to (9,5)
        check("post-rst no early tick", ft_cnt, 0);
        run(1, 0);
        check("post-rst tick", ft_cnt, 1);

        // 1-in-4 strobe: counts step exactly once per 4 clks.
        do_reset();
        mh = '0;
        mv = '0;
        exp_q.delete();
        for (int k = 0; k <= LAT; k++) exp_q.push_back(20'd0);
        for (int i = 0; i < 4 * H_TOT * 2 + 8; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            check($sformatf("div4 pos c%0d", i), int'({pix_x, pix_y}), int'(exp_v));
            pix_en = ((i % 4) == 0);
            if (pix_en) begin
                if (mh == 10'(H_TOT - 1)) begin
                    mh = '0;
                    mv = (mv == 10'(V_TOT - 1)) ? 10'd0 : mv + 10'd1;
                end else begin
                    mh = mh + 10'd1;
                end
            end
            exp_q.push_back({mh, mv});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL expose parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL expose parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL expose parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 The block SHALL expose parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL expose parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33, the vertical equivalents in lines.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  system clock; the only clock; all flops on posedge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 pix_en  input  1  pixel-rate strobe, synchronous to clk, from the divider stage; one pixel step per clk with pix_en=1.
REQ-010 hsync  output  1  horizontal sync, active low.
REQ-011 vsync  output  1  vertical sync, active low.
REQ-012 video_on  output  1  high while the current pixel is inside the visible area.
REQ-013 pix_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-014 pix_y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-015 frame_tick  output  1  single-clk pulse at the start of vertical blanking, for game-state update.

Function
REQ-016 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL SHALL equal V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
REQ-017 h_cnt SHALL increment only on clk edges with pix_en=1 and wrap from H_TOTAL-1 to 0.
REQ-018 v_cnt SHALL increment only on the edge where h_cnt wraps, and wrap from V_TOTAL-1 to 0 on the same edge.
REQ-019 With pix_en=0, all counters and outputs SHALL hold.
REQ-020 Each axis SHALL run a four-state phase machine ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with transitions at counts VISIBLE, VISIBLE+FP, VISIBLE+FP+SYNC, and TOTAL (wrap).
REQ-021 hsync SHALL be 0 exactly while the horizontal phase is SYNC (default h_cnt 656..751); vsync SHALL be 0 exactly while the vertical phase is SYNC (default v_cnt 490..491).
REQ-022 video_on SHALL be 1 iff both phases are ACTIVE (h_cnt<640 and v_cnt<480).
REQ-023 pix_x/pix_y SHALL equal h_cnt/v_cnt, and all outputs SHALL update on the same edge as the counters, with no combinational path from pix_en.
REQ-024 frame_tick SHALL be 1 for exactly one clk cycle: the cycle after the edge that moves (h_cnt,v_cnt) from (639,479) to (640,479).
REQ-025 frame_tick SHALL be 1 for exactly one clk cycle even if pix_en stays 0 after that edge.
REQ-026 With pix_en tied to 1, the block SHALL produce a full frame every 800*525 = 420000 clk cycles.

Reset
REQ-027 rst=1 SHALL immediately force h_cnt=0, v_cnt=0, both phases ACTIVE, hsync=1, vsync=1, frame_tick=0, and video_on=0.
REQ-028 video_on SHALL stay 0 after reset release until the first pix_en; normal decoding applies from then on.
REQ-029 rst asserted mid-line or mid-frame SHALL abandon the frame with no residual frame_tick.

Configuration
REQ-030 With VGA_OUT_REG_EN defined, hsync, vsync, video_on, pix_x, pix_y and frame_tick SHALL pass through one extra clk register stage, delayed uniformly by one clk, with reset values per REQ-027.
REQ-031 Without VGA_OUT_REG_EN, outputs SHALL come directly from the state registers per REQ-023.

Structure
REQ-032 Package vga_timing_pkg SHALL hold the phase enum (ACTIVE, FRONT, SYNC, BACK) and the default 640x480@60 timing constants.
REQ-033 Sub-module vga_axis_counter (count, phase FSM, wrap output) SHALL be instantiated twice: horizontal, and vertical enabled by the horizontal wrap.

Verification
REQ-034 Reset then pix_en=1 for 800 clks -> hsync low for exactly 96 clks starting at h_cnt=656; pix_y=1 after the 800th pix_en.
REQ-035 pix_en=1 one clk in four for 2 frames -> every count steps once per 4 clks; frame period is 1680000 clks.
REQ-036 Run to (639,479) with one more pix_en, then pix_en=0 for 10 clks -> frame_tick high for exactly 1 clk; all other outputs hold.
REQ-037 Run to (799,524) with one pix_en -> counts become (0,0), video_on=1, vsync=1.
REQ-038 Assert rst at (300,200) -> counts 0, hsync=1, vsync=1, video_on=0 immediately; no frame_tick before the next (640,479) crossing.
REQ-039 Build with VGA_OUT_REG_EN -> all output waveforms equal the non-macro build shifted by exactly one clk.
